// File: rtl/jogo_genius_param_if.sv
// Genius game pin bundle: player controls into the core, display and status back out.
// Pure wiring, no latency.
// No backpressure: buttons are sampled every cycle, status outputs are level-valid.
interface jogo_genius_param_if #(
    parameter int N_BOTOES = 4,
    parameter int W        = 4
);
    logic [N_BOTOES-1:0] botoes;
    logic                jogar;
    logic                modo;
    logic [N_BOTOES-1:0] leds;
    logic                ganhou;
    logic                perdeu;
    logic                pronto;
    logic                db_timeout;
    logic [3:0]          db_estado;
    logic [W-1:0]        db_rodada;
    logic [W-1:0]        db_jogada;

    // Player / test side: drives the controls, observes the game.
    modport master (
        output botoes, jogar, modo,
        input  leds, ganhou, perdeu, pronto, db_timeout, db_estado, db_rodada, db_jogada
    );

    // Game core side.
    modport slave (
        input  botoes, jogar, modo,
        output leds, ganhou, perdeu, pronto, db_timeout, db_estado, db_rodada, db_jogada
    );
endinterface

// File: rtl/jogo_genius_param.sv
// Parameterised Genius (Simon) game: shows a growing one-hot sequence, checks the replay.
// Status outputs are one register stage after the state decision; leds are combinational.
// No backpressure: a play is a rising edge of "any button", held buttons never repeat.
module jogo_genius_param #(
    parameter int N_BOTOES     = 4,
    parameter int PROFUNDIDADE = 16,
    parameter int TIMEOUT      = 5000,
    parameter int T_LED        = 500,
    parameter int T_GAP        = 250,
    localparam int W           = $clog2(PROFUNDIDADE)
) (
    input  logic              clock,
    input  logic              reset,
    jogo_genius_param_if.slave io
);
    localparam int SW   = $clog2(N_BOTOES);
    localparam int MAXT = (TIMEOUT > T_LED) ? ((TIMEOUT > T_GAP) ? TIMEOUT : T_GAP)
                                            : ((T_LED > T_GAP) ? T_LED : T_GAP);
    localparam int CW   = $clog2(MAXT + 1);

    localparam logic [CW-1:0]       FIM_LED  = CW'(T_LED - 1);
    localparam logic [CW-1:0]       FIM_GAP  = CW'(T_GAP - 1);
    localparam logic [CW-1:0]       FIM_TOUT = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]        R_MAX    = W'(PROFUNDIDADE - 1);
    localparam logic [N_BOTOES-1:0] UM       = N_BOTOES'(1);

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARA        = 4'h1,
        ST_GERA           = 4'h2,
        ST_MOSTRA         = 4'h3,
        ST_INTERVALO      = 4'h4,
        ST_ESPERA         = 4'h5,
        ST_COMPARA        = 4'h6,
        ST_PROXIMA_JOGADA = 4'h7,
        ST_ESPERA_NOVA    = 4'h8,
        ST_GRAVA          = 4'h9,
        ST_PROXIMA_RODADA = 4'hA,
        ST_GANHOU         = 4'hB,
        ST_PERDEU         = 4'hC,
        ST_TIMEOUT        = 4'hD
    } estado_t;

    estado_t             estado;
    estado_t             prox;

    // Sequence memory: deliberately not reset, contents only matter once written.
    logic [N_BOTOES-1:0] mem [PROFUNDIDADE];

    logic [N_BOTOES-1:0] botoes_ant;
    logic [N_BOTOES-1:0] jogada;
    logic [SW-1:0]       sorteio;
    logic [W-1:0]        r;
    logic [W-1:0]        j;
    logic [W-1:0]        end_grava;
    logic [W-1:0]        db_jogada_q;
    logic [CW-1:0]       cont;
    logic                modo_reg;
    logic                primeira;
    logic                tem_jogada;
    logic                multipla;
    logic                errada;
    logic                ganhou_q;
    logic                perdeu_q;
    logic                pronto_q;
    logic                timeout_q;

    // Lowest set button index; a multi-button play still shows something sensible.
    function automatic logic [W-1:0] indice(input logic [N_BOTOES-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    assign tem_jogada = (io.botoes != '0) && (botoes_ant == '0);
    assign multipla   = (io.botoes & (io.botoes - UM)) != '0;
    assign errada     = (jogada != mem[j]) || ((jogada & (jogada - UM)) != '0);
    assign end_grava  = primeira ? '0 : r + W'(1);

    // Next-state decision; the registered state and outputs are updated from it below.
    always_comb begin
        prox = estado;
        case (estado)
            ST_INICIAL:        if (io.jogar) prox = ST_PREPARA;
            ST_PREPARA:        prox = io.modo ? ST_ESPERA_NOVA : ST_GERA;
            ST_GERA:           prox = ST_MOSTRA;
            ST_MOSTRA:         if (cont == FIM_LED) prox = ST_INTERVALO;
            ST_INTERVALO:      if (cont == FIM_GAP) prox = (j == r) ? ST_ESPERA : ST_MOSTRA;
            ST_ESPERA: begin
                if (tem_jogada)            prox = ST_COMPARA;
                else if (cont == FIM_TOUT) prox = ST_TIMEOUT;
            end
            ST_COMPARA:        prox = errada ? ST_PERDEU : ST_PROXIMA_JOGADA;
            ST_PROXIMA_JOGADA: begin
                if (j != r)          prox = ST_ESPERA;
                else if (r == R_MAX) prox = ST_GANHOU;
                else if (modo_reg)   prox = ST_ESPERA_NOVA;
                else                 prox = ST_PROXIMA_RODADA;
            end
            ST_ESPERA_NOVA: begin
                if (tem_jogada)            prox = multipla ? ST_PERDEU : ST_GRAVA;
                else if (cont == FIM_TOUT) prox = ST_TIMEOUT;
            end
            ST_GRAVA:          prox = primeira ? ST_MOSTRA : ST_PROXIMA_RODADA;
            ST_PROXIMA_RODADA: prox = modo_reg ? ST_MOSTRA : ST_GERA;
            ST_GANHOU, ST_PERDEU, ST_TIMEOUT: if (io.jogar) prox = ST_PREPARA;
            default:           prox = ST_INICIAL;
        endcase
    end

    // State register, round/play indices, shared timer, sampled mode and registered status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= ST_INICIAL;
            sorteio     <= '0;
            botoes_ant  <= '0;
            jogada      <= '0;
            r           <= '0;
            j           <= '0;
            cont        <= '0;
            modo_reg    <= 1'b0;
            primeira    <= 1'b0;
            db_jogada_q <= '0;
            ganhou_q    <= 1'b0;
            perdeu_q    <= 1'b0;
            pronto_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            estado     <= prox;
            sorteio    <= sorteio + SW'(1);
            botoes_ant <= io.botoes;
            // One timer serves display, gap and idle timeout: it restarts on every state change.
            cont       <= (prox != estado) ? '0 : cont + CW'(1);
            case (estado)
                ST_PREPARA: begin
                    r           <= '0;
                    j           <= '0;
                    modo_reg    <= io.modo;
                    primeira    <= 1'b1;
                    db_jogada_q <= '0;
                end
                ST_GERA:           j <= '0;
                ST_INTERVALO: begin
                    if (prox == ST_MOSTRA)      j <= j + W'(1);
                    else if (prox == ST_ESPERA) j <= '0;
                end
                ST_ESPERA, ST_ESPERA_NOVA: begin
                    if (tem_jogada) begin
                        jogada      <= io.botoes;
                        db_jogada_q <= indice(io.botoes);
                    end
                end
                ST_PROXIMA_JOGADA: if (prox == ST_ESPERA) j <= j + W'(1);
                ST_GRAVA: begin
                    primeira <= 1'b0;
                    j        <= '0;
                end
                ST_PROXIMA_RODADA: begin
                    r <= r + W'(1);
                    j <= '0;
                end
                default: ;
            endcase
            ganhou_q  <= (prox == ST_GANHOU);
            perdeu_q  <= (prox == ST_PERDEU) || (prox == ST_TIMEOUT);
            timeout_q <= (prox == ST_TIMEOUT);
            pronto_q  <= (prox == ST_GANHOU) || (prox == ST_PERDEU) || (prox == ST_TIMEOUT);
        end
    end

    // Sequence writes: a fresh random entry in GERA, the player's new entry in GRAVA.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (estado == ST_GERA)       mem[r]         <= UM << sorteio;
            else if (estado == ST_GRAVA) mem[end_grava] <= jogada;
        end
    end

    // Display mux: sequence while showing, dark in the gap, otherwise mirror the buttons.
    always_comb begin
        case (estado)
            ST_MOSTRA:    io.leds = mem[j];
            ST_INTERVALO: io.leds = '0;
            default:      io.leds = io.botoes;
        endcase
    end

    assign io.db_estado  = estado;
    assign io.db_rodada  = r;
    assign io.db_jogada  = db_jogada_q;
    assign io.ganhou     = ganhou_q;
    assign io.perdeu     = perdeu_q;
    assign io.pronto     = pronto_q;
    assign io.db_timeout = timeout_q;
endmodule

// File: doc/jogo_genius_param.md
JOGO_GENIUS_PARAM -- requirements
Module: jogo_genius_param

Interface
REQ-001 The block SHALL have parameter N_BOTOES, default 4, giving the number of button/LED channels (power of two, >=2).
REQ-002 The block SHALL have parameter PROFUNDIDADE, default 16, giving the maximum number of rounds and the sequence-memory depth; W = clog2(PROFUNDIDADE).
REQ-003 The block SHALL have parameter TIMEOUT, default 5000, giving the idle cycles allowed while waiting for a play.
REQ-004 The block SHALL have parameter T_LED, default 500, giving the cycles each sequence LED is lit during display.
REQ-005 The block SHALL have parameter T_GAP, default 250, giving the dark cycles after each displayed LED.
REQ-006 The block SHALL have these ports: clock in 1 (sole clock, rising edge); reset in 1 (synchronous, active-low); botoes in N_BOTOES (player buttons); jogar in 1 (start/restart); modo in 1 (0 = block-generated sequence, 1 = player-extended sequence); leds out N_BOTOES; ganhou out 1; perdeu out 1; pronto out 1; db_timeout out 1; db_estado out 4; db_rodada out W; db_jogada out W.

Function
REQ-007 The block SHALL detect a play (jogada) only on a cycle where botoes != 0 and the registered previous botoes == 0; a held button SHALL never produce a second play.
REQ-008 The block SHALL treat a play with more than one botoes bit set as a wrong play.
REQ-009 The block SHALL contain a PROFUNDIDADE x N_BOTOES sequence RAM holding one-hot entries; RAM contents are not cleared by reset.
REQ-010 The block SHALL run a free-running mod-N_BOTOES counter (sorteio), cleared by reset, incremented every cycle.
REQ-011 The FSM SHALL have states (db_estado code): INICIAL 0, PREPARA 1, GERA 2, MOSTRA 3, INTERVALO 4, ESPERA 5, COMPARA 6, PROXIMA_JOGADA 7, ESPERA_NOVA 8, GRAVA 9, PROXIMA_RODADA A, GANHOU B, PERDEU C, TIMEOUT D.
REQ-012 INICIAL SHALL go to PREPARA on jogar=1; PREPARA SHALL clear round r, play index j, timers and sample modo into an internal register, then go to GERA in mode 0 or GRAVA in mode 1 (first entry = next play, via ESPERA_NOVA).
REQ-013 GERA (mode 0) SHALL write one-hot(sorteio) to RAM[r] in one cycle, then go to MOSTRA with j=0.
REQ-014 MOSTRA SHALL drive leds = RAM[j] for exactly T_LED cycles, then INTERVALO drives leds = 0 for T_GAP cycles; after entry j=r, go to ESPERA with j=0, else j+1 and back to MOSTRA.
REQ-015 In MOSTRA and INTERVALO botoes SHALL be ignored; in all other states leds SHALL equal botoes.
REQ-016 ESPERA SHALL go to COMPARA on a play, registering it; COMPARA SHALL go to PERDEU if play != RAM[j], else to PROXIMA_JOGADA.
REQ-017 PROXIMA_JOGADA SHALL: if j<r, j+1 and ESPERA; if j=r and r=PROFUNDIDADE-1, GANHOU; if j=r in mode 0, PROXIMA_RODADA; if j=r in mode 1, ESPERA_NOVA.
REQ-018 ESPERA_NOVA (mode 1) SHALL go to GRAVA on a play; a multi-bit play SHALL go to PERDEU; GRAVA SHALL write the play to RAM[r+1] (RAM[0] from PREPARA) and go to PROXIMA_RODADA (MOSTRA with r=0 from PREPARA).
REQ-019 PROXIMA_RODADA SHALL increment r and go to GERA (mode 0) or MOSTRA with j=0 (mode 1).
REQ-020 A timeout counter SHALL clear on entry to ESPERA/ESPERA_NOVA and on every play; reaching TIMEOUT cycles in either state SHALL go to TIMEOUT.
REQ-021 GANHOU, PERDEU, TIMEOUT SHALL be holding states; jogar=1 there SHALL go to PREPARA; jogar in any other non-INICIAL state SHALL be ignored.
REQ-022 Outputs SHALL be registered: ganhou=1 only in GANHOU; perdeu=1 in PERDEU and TIMEOUT; db_timeout=1 only in TIMEOUT; pronto=1 in all three final states.
REQ-023 db_rodada SHALL show r and db_jogada SHALL show the index (encoded) of the last registered play.
REQ-024 A modo change after PREPARA SHALL have no effect until the next PREPARA.

Reset
REQ-025 On clock edge with reset=0 the FSM SHALL enter INICIAL from any state, mid-display or mid-play included, and r, j, sorteio, timers, ganhou, perdeu, pronto, db_timeout, db_rodada, db_jogada SHALL be 0; leds SHALL follow botoes.

Verification (N_BOTOES=4, PROFUNDIDADE=4, TIMEOUT=20, T_LED=3, T_GAP=2)
REQ-026 Mode 0 full game: replay every displayed entry correctly for 4 rounds -> ganhou=1, pronto=1, db_rodada=3, db_estado=B.
REQ-027 Mode 0 round 2, second play wrong (0100 vs 0001) -> perdeu=1, ganhou=0, db_estado=C next cycle after COMPARA.
REQ-028 Mode 1: plays 0001, 0001, 0010, then 0001,0010,1000... -> RAM[0..2]=0001,0010,1000, each MOSTRA shows exactly r+1 LEDs of 3 cycles with 2-cycle gaps.
REQ-029 No play for 20 cycles in ESPERA -> db_timeout=1, perdeu=1, db_estado=D; jogar=1 -> db_estado=1 next cycle, outputs cleared.
REQ-030 Button held from MOSTRA into ESPERA, multi-button 0011 play, and reset=0 asserted during MOSTRA -> no play counted, PERDEU, INICIAL with all outputs 0 respectively.
